trigger_seq_gen: RTL and testbench

//  Parametrised N-stage pulse-sequence trigger for the FMC ADC capture path. Watches pair-summed
//  ADC channels and arms stages in order. Each stage has a +/- window and a dead time. Measures

---
 rtl/trigger_seq_gen.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_trigger_seq_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_seq_gen.sv
// trigger_seq_gen
//   N-stage pulse-sequence trigger for the ADC capture path. Each ADC word
//   holds two samples; they are summed per channel and the sum is compared
//   against a +/- window for the stage being watched. Stages are armed in
//   order, with a dead time after each detect. The stage0->stage1 time of
//   flight is measured in cycles. A Q16.16 delay is built from it, and a
//   one-cycle trigger fires once that delay has run out after the last stage.
//
// Ports
//   rxclk, rxrst_n   ADC clock, async active-low reset
//   adc_data         32 bits per channel, low half = first sample
//   adc_enable       per-channel sum register update enable
//   trig_enable      0 holds the sequencer in IDLE and clears outputs
//   auto_rearm       1: return to IDLE after FIRE, 0: park in DONE
//   stage_sel        channel watched by each stage (>= N_CH: never hits)
//   trig_level       per stage {upper P, lower M}, signed 16-bit each
//   idle_time        cycles from enable/rearm to arming stage 0
//   hold_time        dead-time cycles after each detect
//   wait_timeout     max armed cycles per stage after stage 0, 0 = none
//   param_mul        signed Q16.16 added per TOF cycle
//   param_off        signed Q16.16 added once at the stage-1 detect
//   pulse_tof        stage0->stage1 cycles of the last completed measurement
//   detect_pls       bit s = stage s detected, top bit = trigger fired
//   trig_out         one-cycle trigger pulse
//   timeout_flag     sticky stage-timeout flag
//   state_o          FSM state for debug
module trigger_seq_gen #(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int N_CH           = 4,
    parameter int N_STAGES       = 3,
    parameter int CH_W           = 2
) (
    input  logic                       rxclk,
    input  logic                       rxrst_n,
    input  logic [32*N_CH-1:0]         adc_data,
    input  logic [N_CH-1:0]            adc_enable,
    input  logic                       trig_enable,
    input  logic                       auto_rearm,
    input  logic [CH_W*N_STAGES-1:0]   stage_sel,
    input  logic [32*N_STAGES-1:0]     trig_level,
    input  logic [31:0]                idle_time,
    input  logic [31:0]                hold_time,
    input  logic [31:0]                wait_timeout,
    input  logic [31:0]                param_mul,
    input  logic [31:0]                param_off,
    output logic [31:0]                pulse_tof,
    output logic [N_STAGES:0]          detect_pls,
    output logic                       trig_out,
    output logic                       timeout_flag,
    output logic [2:0]                 state_o
);

    localparam int SUM_W = ADC_DATA_WIDTH + 1;
    localparam int STG_W = $clog2(N_STAGES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        HOLD  = 3'd2,
        DELAY = 3'd3,
        FIRE  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Signed add that clamps to 0x7FFF_FFFF / 0x8000_0000 instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            sat_add = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sat_add = s[31:0];
        end
    endfunction

    // ---------------- per-channel pair sums ----------------
    logic [SUM_W-1:0] sum_d [N_CH];
    logic [SUM_W-1:0] sum_q [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_sum
        logic [ADC_DATA_WIDTH-1:0] lo;
        logic [ADC_DATA_WIDTH-1:0] hi;
        assign lo       = adc_data[32*k +: ADC_DATA_WIDTH];
        assign hi       = adc_data[32*k+16 +: ADC_DATA_WIDTH];
        assign sum_d[k] = {lo[ADC_DATA_WIDTH-1], lo} + {hi[ADC_DATA_WIDTH-1], hi};
    end

    always_ff @(posedge rxclk or negedge rxrst_n) begin
        if (!rxrst_n) begin
            for (int k = 0; k < N_CH; k++) sum_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (adc_enable[k]) sum_q[k] <= sum_d[k];
            end
        end
    end

    // ---------------- per-stage window compare ----------------
    // Levels are doubled ({lvl,1'b0}) so they sit on the same scale as a
    // two-sample sum. Everything is widened to 33 bits signed before compare.
    logic [N_STAGES-1:0] stage_hit;

    for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
        logic [CH_W-1:0]    sel;
        logic [SUM_W-1:0]   sum_sel;
        logic               sel_ok;
        logic signed [32:0] sum_x;
        logic signed [32:0] thr_p;
        logic signed [32:0] thr_m;

        assign sel = stage_sel[s*CH_W +: CH_W];

        always_comb begin
            sum_sel = '0;
            sel_ok  = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (sel == CH_W'(k)) begin
                    sum_sel = sum_q[k];
                    sel_ok  = 1'b1;
                end
            end
        end

        assign sum_x = {{(33-SUM_W){sum_sel[SUM_W-1]}}, sum_sel};
        assign thr_p = {{16{trig_level[32*s+31]}}, trig_level[32*s+16 +: 16], 1'b0};
        assign thr_m = {{16{trig_level[32*s+15]}}, trig_level[32*s +: 16], 1'b0};
        assign stage_hit[s] = sel_ok && ((sum_x > thr_p) || (sum_x < thr_m));
    end

    // ---------------- sequencer ----------------
    state_t             state_q;
    logic [STG_W-1:0]   stg_q;
    logic [31:0]        cnt_q;
    logic [31:0]        armed_cnt_q;
    logic [31:0]        tof_cnt_q;
    logic               tof_run_q;
    logic [31:0]        delay_q;
    logic [31:0]        ctr_q;
    logic [31:0]        pulse_tof_q;
    logic [N_STAGES:0]  detect_q;
    logic               trig_q;
    logic               timeout_q;

    logic               hit_d;
    logic [N_STAGES:0]  stg_onehot_d;
    logic [31:0]        tof_inc_d;
    logic [31:0]        delay_tof_d;
    logic [31:0]        armed_inc_d;

    assign hit_d        = stage_hit[stg_q];
    assign stg_onehot_d = (N_STAGES+1)'(1) << stg_q;
    assign tof_inc_d    = (tof_cnt_q == 32'hFFFF_FFFF) ? tof_cnt_q : tof_cnt_q + 32'd1;
    assign delay_tof_d  = sat_add(delay_q, param_mul);
    assign armed_inc_d  = (armed_cnt_q == 32'hFFFF_FFFF) ? armed_cnt_q : armed_cnt_q + 32'd1;

    always_ff @(posedge rxclk or negedge rxrst_n) begin
        if (!rxrst_n) begin
            state_q     <= IDLE;
            stg_q       <= '0;
            cnt_q       <= '0;
            armed_cnt_q <= '0;
            tof_cnt_q   <= '0;
            tof_run_q   <= 1'b0;
            delay_q     <= '0;
            ctr_q       <= '0;
            pulse_tof_q <= '0;
            detect_q    <= '0;
            trig_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (!trig_enable) begin
            // Disable overrides every other event; pulse_tof survives.
            state_q     <= IDLE;
            stg_q       <= '0;
            cnt_q       <= idle_time;
            armed_cnt_q <= '0;
            tof_run_q   <= 1'b0;
            detect_q    <= '0;
            trig_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;

            // TOF runs through HOLD and ARMED between stage-0 and stage-1
            // detects, including the stage-1 detect cycle itself.
            if (tof_run_q) begin
                tof_cnt_q <= tof_inc_d;
                delay_q   <= delay_tof_d;
            end

            case (state_q)
                IDLE: begin
                    detect_q <= '0;
                    if (cnt_q == 32'd0) begin
                        state_q     <= ARMED;
                        stg_q       <= '0;
                        armed_cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end

                ARMED: begin
                    if (hit_d) begin
                        detect_q <= detect_q | stg_onehot_d;
                        cnt_q    <= hold_time;
                        if (stg_q == '0) begin
                            tof_cnt_q <= '0;
                            delay_q   <= '0;
                            tof_run_q <= 1'b1;
                        end
                        if (stg_q == STG_W'(1)) begin
                            pulse_tof_q <= tof_inc_d;
                            delay_q     <= sat_add(delay_tof_d, param_off);
                            tof_run_q   <= 1'b0;
                        end
                        if (stg_q == STG_W'(N_STAGES-1)) begin
                            state_q <= DELAY;
                            ctr_q   <= '0;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if ((stg_q != '0) && (wait_timeout != 32'd0) &&
                                 (armed_inc_d >= wait_timeout)) begin
                        // armed_inc_d counts this cycle as an armed cycle.
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= idle_time;
                        stg_q     <= '0;
                        detect_q  <= '0;
                        tof_run_q <= 1'b0;
                    end else begin
                        armed_cnt_q <= armed_inc_d;
                    end
                end

                HOLD: begin
                    if (cnt_q == 32'd0) begin
                        state_q     <= ARMED;
                        stg_q       <= stg_q + STG_W'(1);
                        armed_cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end

                DELAY: begin
                    if ($signed(ctr_q) >= $signed(delay_q)) begin
                        state_q            <= FIRE;
                        trig_q             <= 1'b1;
                        detect_q[N_STAGES] <= 1'b1;
                    end else begin
                        ctr_q <= sat_add(ctr_q, 32'h0001_0000);
                    end
                end

                FIRE: begin
                    if (auto_rearm) begin
                        state_q  <= IDLE;
                        cnt_q    <= idle_time;
                        stg_q    <= '0;
                        detect_q <= '0;
                    end else begin
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    state_q <= DONE;
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= idle_time;
                end
            endcase
        end
    end

    assign pulse_tof    = pulse_tof_q;
    assign detect_pls   = detect_q;
    assign trig_out     = trig_q;
    assign timeout_flag = timeout_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_trigger_seq_gen.sv
// Bench for trigger_seq_gen: window vectors from a table, hand-written
// sequences for timeout / channel-select / reset / disable, and randomized
// full sequences checked against an event-time model of the trigger.
module tb_trigger_seq_gen;
  localparam int N_CH     = 4;
  localparam int N_STAGES = 3;
  localparam int CH_W     = 3;

  // ---------------- clock / reset ----------------
  logic                      rxclk = 1'b0;
  logic                      rxrst_n;
  logic [32*N_CH-1:0]        adc_data;
  logic [N_CH-1:0]           adc_enable;
  logic                      trig_enable;
  logic                      auto_rearm;
  logic [CH_W*N_STAGES-1:0]  stage_sel;
  logic [32*N_STAGES-1:0]    trig_level;
  logic [31:0]               idle_time, hold_time, wait_timeout, param_mul, param_off;
  logic [31:0]               pulse_tof;
  logic [N_STAGES:0]         detect_pls;
  logic                      trig_out, timeout_flag;
  logic [2:0]                state_o;

  always #4 rxclk = ~rxclk;

  trigger_seq_gen #(.ADC_DATA_WIDTH(16), .N_CH(N_CH), .N_STAGES(N_STAGES), .CH_W(CH_W)) dut (
    .rxclk(rxclk), .rxrst_n(rxrst_n), .adc_data(adc_data), .adc_enable(adc_enable),
    .trig_enable(trig_enable), .auto_rearm(auto_rearm), .stage_sel(stage_sel),
    .trig_level(trig_level), .idle_time(idle_time), .hold_time(hold_time),
    .wait_timeout(wait_timeout), .param_mul(param_mul), .param_off(param_off),
    .pulse_tof(pulse_tof), .detect_pls(detect_pls), .trig_out(trig_out),
    .timeout_flag(timeout_flag), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int last_tof = 0;

  localparam logic [31:0] TAG_TRIG = 32'h0800_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_event(input string name, input logic [31:0] ev);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s event: got %0h expected none", name, ev);
    end else begin
      e = exp_q.pop_front();
      if (ev !== e) begin
        errors++;
        $display("FAIL %s event: got %0h expected %0h", name, ev, e);
      end
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  function automatic logic [32*N_CH-1:0] pulse_word(input int ch, input logic [15:0] lo,
                                                    input logic [15:0] hi);
    logic [32*N_CH-1:0] w;
    w = '0;
    w[32*ch +: 16]    = lo;
    w[32*ch+16 +: 16] = hi;
    return w;
  endfunction

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic disable_then_enable();
    trig_enable = 1'b0;
    tick();
    tick();
    trig_enable = 1'b1;
  endtask

  // Full three-stage sequence. Pulses land on iterations p[s]; the model
  // predicts detect bit s rising one observation later, and the trigger at
  // p[2] + 2 + ceil(delay / 1.0) where delay = sat(sat(tof*mul) + off).
  task automatic run_seq(input string tag, input bit fresh, input bit rearm,
                         input int idle, input int hold, input int p0, input int g1,
                         input int g2, input logic [31:0] mul, input logic [31:0] off,
                         input logic [CH_W*N_STAGES-1:0] sel);
    int p[N_STAGES];
    int ch[N_STAGES];
    longint d;
    int k;
    int t_fire;
    logic [N_STAGES:0] prev;
    p[0] = p0;
    p[1] = p0 + g1;
    p[2] = p[1] + g2;
    for (int s = 0; s < N_STAGES; s++) ch[s] = int'(sel[s*CH_W +: CH_W]);
    idle_time    = idle;
    hold_time    = hold;
    param_mul    = mul;
    param_off    = off;
    auto_rearm   = rearm;
    stage_sel    = sel;
    wait_timeout = 32'd0;
    trig_level   = {N_STAGES{16'h1000, 16'hF000}};
    adc_data     = '0;
    if (fresh) disable_then_enable();

    d = clamp32(longint'(g1) * longint'($signed(mul)));
    d = clamp32(d + longint'($signed(off)));
    k = (d <= 0) ? 0 : int'((d + 65535) / 65536);
    t_fire = p[2] + 2 + k;

    exp_q.delete();
    for (int s = 0; s < N_STAGES; s++) exp_q.push_back((32'(s) << 24) | 32'(p[s] + 1));
    exp_q.push_back(TAG_TRIG | 32'(t_fire));

    prev = detect_pls;
    for (int i = 0; i <= t_fire + 3; i++) begin
      adc_data = '0;
      for (int s = 0; s < N_STAGES; s++)
        if (i == p[s]) adc_data = pulse_word(ch[s], 16'h4000, 16'h4000);
      tick();
      for (int s = 0; s < N_STAGES; s++)
        if (detect_pls[s] && !prev[s]) note_event(tag, (32'(s) << 24) | 32'(i));
      if (trig_out) note_event(tag, TAG_TRIG | 32'(i));
      if (i == t_fire) check({tag, " detect_at_fire"}, 32'(detect_pls), 32'hF);
      prev = detect_pls;
    end
    adc_data = '0;
    check({tag, " missing_events"}, 32'(exp_q.size()), 32'd0);
    check({tag, " pulse_tof"}, pulse_tof, 32'(g1));
    last_tof = g1;
    if (!rearm) check({tag, " done_state"}, 32'(state_o), 32'd5);
  endtask

  // ---------------- window vector table ----------------
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] p;
    logic [15:0] m;
    bit          hit;
  } win_vec_t;

  win_vec_t win_tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [32*N_CH-1:0] all_ch;

    win_tbl[0] = '{16'h0100, 16'h0100, 16'h0100, 16'hFF00, 1'b0};
    win_tbl[1] = '{16'h0100, 16'h0101, 16'h0100, 16'hFF00, 1'b1};
    win_tbl[2] = '{16'hFF00, 16'hFEFF, 16'h0100, 16'hFF00, 1'b1};
    win_tbl[3] = '{16'hFF00, 16'hFF00, 16'h0100, 16'hFF00, 1'b0};
    win_tbl[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b0};
    win_tbl[5] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};
    win_tbl[6] = '{16'h8000, 16'h8001, 16'h7FFF, 16'h8001, 1'b1};
    win_tbl[7] = '{16'h4000, 16'h4001, 16'h4000, 16'hC000, 1'b1};

    rxrst_n      = 1'b0;
    adc_data     = '0;
    adc_enable   = '1;
    trig_enable  = 1'b0;
    auto_rearm   = 1'b0;
    stage_sel    = {3'd2, 3'd1, 3'd0};
    trig_level   = {N_STAGES{16'h1000, 16'hF000}};
    idle_time    = 32'd0;
    hold_time    = 32'd0;
    wait_timeout = 32'd0;
    param_mul    = 32'h0001_0000;
    param_off    = 32'd0;

    // reset state
    #20;
    check("rst pulse_tof", pulse_tof, 32'd0);
    check("rst detect", 32'(detect_pls), 32'd0);
    check("rst trig", 32'(trig_out), 32'd0);
    check("rst timeout", 32'(timeout_flag), 32'd0);
    check("rst state", 32'(state_o), 32'd0);
    @(negedge rxclk);
    rxrst_n = 1'b1;
    tick();

    // window boundaries on stage 0
    for (int v = 0; v < 8; v++) begin
      trig_enable = 1'b0;
      trig_level  = {N_STAGES{win_tbl[v].p, win_tbl[v].m}};
      idle_time   = 32'd0;
      hold_time   = 32'd1000;
      stage_sel   = {3'd2, 3'd1, 3'd0};
      adc_data    = '0;
      tick();
      tick();
      trig_enable = 1'b1;
      tick(); tick(); tick();
      adc_data = pulse_word(0, win_tbl[v].lo, win_tbl[v].hi);
      tick();
      adc_data = '0;
      tick(); tick(); tick();
      check($sformatf("window[%0d]", v), 32'(detect_pls[0]), 32'(win_tbl[v].hit));
    end

    // basic sequence: tof 50, trigger 51 cycles after stage-2 detect
    run_seq("basic", 1'b1, 1'b0, 4, 10, 100, 50, 150, 32'h0001_0000, 32'd0,
            {3'd2, 3'd1, 3'd0});

    // stage 1 watching ch3
    run_seq("sel_ch3", 1'b1, 1'b0, 2, 5, 8, 20, 15, 32'h0000_8000, 32'h0002_0000,
            {3'd2, 3'd3, 3'd0});

    // delay saturation: 10 * 0x7FFF_FFFF clamps, offset pulls it to 0xFFFF
    run_seq("sat", 1'b1, 1'b0, 2, 3, 10, 10, 10, 32'h7FFF_FFFF, 32'h8001_0000,
            {3'd2, 3'd1, 3'd0});

    // auto-rearm: two sequences back to back, two trigger pulses
    run_seq("rearm1", 1'b1, 1'b1, 3, 4, 7, 12, 9, 32'h0001_0000, 32'd0, {3'd2, 3'd1, 3'd0});
    run_seq("rearm2", 1'b0, 1'b1, 3, 4, 9, 17, 9, 32'h0000_4000, 32'h0003_0000,
            {3'd2, 3'd1, 3'd0});

    // randomized sequences
    for (int r = 0; r < 8; r++) begin
      int hold_r, offi;
      logic [31:0] mul_r;
      logic [CH_W*N_STAGES-1:0] sel_r;
      hold_r = int'($urandom_range(0, 8));
      mul_r  = 32'($urandom_range(0, 32'h0003_0000));
      if ($urandom_range(0, 3) == 0) mul_r = -mul_r;
      offi   = int'($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000;
      for (int s = 0; s < N_STAGES; s++) sel_r[s*CH_W +: CH_W] = CH_W'($urandom_range(0, N_CH-1));
      run_seq($sformatf("rand%0d", r), 1'b1, 1'b0, int'($urandom_range(0, 6)), hold_r,
              10, hold_r + 3 + int'($urandom_range(0, 40)), hold_r + 3 + int'($urandom_range(0, 40)),
              mul_r, 32'(offi), sel_r);
    end

    // stage 1 on channel 5 (out of range) never detects
    stage_sel = {3'd2, 3'd5, 3'd0};
    idle_time = 32'd0;
    hold_time = 32'd2;
    trig_level = {N_STAGES{16'h1000, 16'hF000}};
    disable_then_enable();
    tick(); tick(); tick();
    adc_data = pulse_word(0, 16'h4000, 16'h4000);
    tick();
    all_ch = '0;
    for (int c = 0; c < N_CH; c++) all_ch = all_ch | pulse_word(c, 16'h4000, 16'h4000);
    for (int i = 0; i < 12; i++) begin
      adc_data = (i % 3 == 2) ? all_ch : '0;
      tick();
    end
    adc_data = '0;
    check("sel5 detect", 32'(detect_pls), 32'h1);
    check("sel5 state", 32'(state_o), 32'd1);

    // stage timeout after 20 armed cycles
    stage_sel    = {3'd2, 3'd1, 3'd0};
    idle_time    = 32'd0;
    hold_time    = 32'd5;
    wait_timeout = 32'd20;
    disable_then_enable();
    tick(); tick(); tick();
    for (int i = 0; i <= 40; i++) begin
      adc_data = (i == 0) ? pulse_word(0, 16'h4000, 16'h4000) : '0;
      tick();
      if (i == 26) begin
        check("tmo before flag", 32'(timeout_flag), 32'd0);
        check("tmo before state", 32'(state_o), 32'd1);
      end
      if (i == 27) begin
        check("tmo flag", 32'(timeout_flag), 32'd1);
        check("tmo state", 32'(state_o), 32'd0);
        check("tmo detect", 32'(detect_pls), 32'd0);
      end
    end
    check("tmo sticky", 32'(timeout_flag), 32'd1);
    trig_enable = 1'b0;
    tick();
    check("tmo cleared", 32'(timeout_flag), 32'd0);
    wait_timeout = 32'd0;

    // trig_enable drop mid-HOLD
    hold_time = 32'd10;
    disable_then_enable();
    tick(); tick(); tick();
    adc_data = pulse_word(0, 16'h4000, 16'h4000);
    tick();
    adc_data = '0;
    tick(); tick(); tick();
    check("drop in_hold", 32'(state_o), 32'd2);
    check("drop detect_before", 32'(detect_pls), 32'd1);
    trig_enable = 1'b0;
    tick();
    check("drop state", 32'(state_o), 32'd0);
    check("drop detect", 32'(detect_pls), 32'd0);
    check("drop keeps tof", pulse_tof, 32'(last_tof));

    // async reset mid-DELAY
    hold_time = 32'd2;
    param_mul = 32'h0001_0000;
    param_off = 32'd0;
    disable_then_enable();
    tick(); tick(); tick();
    for (int i = 0; i <= 25; i++) begin
      adc_data = '0;
      if (i == 0)  adc_data = pulse_word(0, 16'h4000, 16'h4000);
      if (i == 10) adc_data = pulse_word(1, 16'h4000, 16'h4000);
      if (i == 20) adc_data = pulse_word(2, 16'h4000, 16'h4000);
      tick();
    end
    adc_data = '0;
    check("rstd in_delay", 32'(state_o), 32'd3);
    check("rstd tof_before", pulse_tof, 32'd10);
    #1;
    rxrst_n = 1'b0;
    #1;
    check("rstd state", 32'(state_o), 32'd0);
    check("rstd tof", pulse_tof, 32'd0);
    check("rstd detect", 32'(detect_pls), 32'd0);
    check("rstd trig", 32'(trig_out), 32'd0);
    check("rstd timeout", 32'(timeout_flag), 32'd0);
    @(negedge rxclk);
    rxrst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
